// File: rtl/kp_pkg.sv
// Shared types, key codes and the keypad keymap for the keypad scan controller.
package kp_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StEmit,
    StRelease
  } kp_state_e;

  localparam logic [3:0] KP_CLEAR = 4'h0;
  localparam logic [3:0] KP_HASH  = 4'hF;

  // Digits n map to n+1 so that code 0 stays free for the clear ('*') key.
  function automatic logic [3:0] kp_keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = KP_CLEAR;
    case ({r, c})
      4'h0: code = 4'h2;      // '1'
      4'h1: code = 4'h3;      // '2'
      4'h2: code = 4'h4;      // '3'
      4'h3: code = 4'hB;      // 'A'
      4'h4: code = 4'h5;      // '4'
      4'h5: code = 4'h6;      // '5'
      4'h6: code = 4'h7;      // '6'
      4'h7: code = 4'hC;      // 'B'
      4'h8: code = 4'h8;      // '7'
      4'h9: code = 4'h9;      // '8'
      4'hA: code = 4'hA;      // '9'
      4'hB: code = 4'hD;      // 'C'
      4'hC: code = KP_CLEAR;  // '*'
      4'hD: code = 4'h1;      // '0'
      4'hE: code = KP_HASH;   // '#'
      4'hF: code = 4'hE;      // 'D'
      default: code = KP_CLEAR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/kp_scan_ctrl_if.sv
// Keypad-side and shift-register-side signals of the keypad scan controller.
interface kp_scan_ctrl_if;
  logic [3:0] col;
  logic [3:0] row;
  logic       shift;
  logic [3:0] d;
  logic       key_held;

  modport master (input col, output row, output shift, output d, output key_held);
  modport slave  (output col, input row, input shift, input d, input key_held);
endinterface

// File: rtl/kp_key_encode.sv
// Combinational key encoder: lowest low column of the driven row wins.
module kp_key_encode
  import kp_pkg::*;
(
  input  logic [1:0] row_idx_i,
  input  logic [3:0] col_i,
  output logic       hit_o,
  output logic [1:0] col_idx_o,
  output logic [3:0] code_o
);

  always_comb begin
    hit_o     = ~&col_i;
    col_idx_o = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_i[i]) col_idx_o = 2'(i);
    end
    code_o = kp_keymap(row_idx_i, col_idx_o);
  end

endmodule

// File: rtl/kp_scan_ctrl.sv
// 4x4 keypad scanner: walks rows, debounces one press and emits one shift strobe per press.
module kp_scan_ctrl
  import kp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  kp_scan_ctrl_if.master bus
);

  localparam int unsigned TimerW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  kp_state_e   state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [1:0]  cap_col_q, cap_col_d;
  logic [3:0]  d_q, d_d;
  logic        key_held_q, key_held_d;
  logic [3:0]  sync1_q, sync2_q;

  logic        hit;
  logic [1:0]  hit_col;
  logic [3:0]  hit_code;
  logic        sample;
  logic        cnt_last;

  kp_key_encode u_enc (
    .row_idx_i (row_idx_q),
    .col_i     (sync2_q),
    .hit_o     (hit),
    .col_idx_o (hit_col),
    .code_o    (hit_code)
  );

  assign sample   = (timer_q == TimerW'(SCAN_DIV - 1));
  // The count holds matches seen so far; this sample completes the run when it is the last one.
  assign cnt_last = ((32'(cnt_q) + 32'd1) == DEBOUNCE);

  always_comb begin
    state_d    = state_q;
    timer_d    = sample ? '0 : timer_q + TimerW'(1);
    cnt_d      = cnt_q;
    row_idx_d  = row_idx_q;
    cap_col_d  = cap_col_q;
    d_d        = d_q;
    key_held_d = key_held_q;
    unique case (state_q)
      StScan: begin
        if (sample) begin
          if (hit) begin
            cap_col_d = hit_col;
            if (DEBOUNCE == 1) begin
              state_d    = StEmit;
              d_d        = hit_code;
              key_held_d = 1'b1;
            end else begin
              state_d = StDebounce;
              cnt_d   = CntW'(1);
            end
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
      end
      StDebounce: begin
        if (sample) begin
          if (hit && (hit_col == cap_col_q)) begin
            if (cnt_last) begin
              state_d    = StEmit;
              d_d        = hit_code;
              key_held_d = 1'b1;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            state_d   = StScan;
            cnt_d     = '0;
            row_idx_d = row_idx_q + 2'd1;
          end
        end
      end
      StEmit: begin
        state_d = StRelease;
        cnt_d   = '0;
      end
      StRelease: begin
        if (sample) begin
          if (!hit) begin
            if (cnt_last) begin
              state_d    = StScan;
              key_held_d = 1'b0;
              cnt_d      = '0;
              row_idx_d  = row_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StScan;
      timer_q    <= '0;
      cnt_q      <= '0;
      row_idx_q  <= 2'd0;
      cap_col_q  <= 2'd0;
      d_q        <= KP_CLEAR;
      key_held_q <= 1'b0;
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      row_idx_q  <= row_idx_d;
      cap_col_q  <= cap_col_d;
      d_q        <= d_d;
      key_held_q <= key_held_d;
      sync1_q    <= bus.col;
      sync2_q    <= sync1_q;
    end
  end

  assign bus.row      = ~(4'b0001 << row_idx_q);
  assign bus.shift    = (state_q == StEmit);
  assign bus.d        = d_q;
  assign bus.key_held = key_held_q;

endmodule
